// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: timed two-road intersection phase scheduler with pedestrian walk interval
module traffic_phase_sched #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 6,
  parameter int CNT_W     = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ew_car,
  input  logic       ns_car,
  input  logic       ped_req,
  output logic [1:0] ew_lite,
  output logic [1:0] ns_lite,
  output logic       walk,
  output logic [2:0] phase
);
  localparam logic [2:0] S_EW_GRN = 3'd0, S_EW_YEL = 3'd1, S_RED_A = 3'd2, S_NS_GRN = 3'd3,
                         S_NS_YEL = 3'd4, S_RED_B = 3'd5, S_WALK = 3'd6;
  localparam logic [CNT_W-1:0] T_MIN = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] T_RED = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] T_WLK = CNT_W'(WALK_T - 1);
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pend_q, ped_pend_d;
  logic             dir_ns_q, dir_ns_d;
  logic             green, own, opp, green_done;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_EW_GRN;
      timer_q    <= '0;
      ped_pend_q <= 1'b0;
      dir_ns_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      dir_ns_q   <= dir_ns_d;
    end
  end
  always_comb begin
    green      = (state_q == S_EW_GRN) || (state_q == S_NS_GRN);
    own        = (state_q == S_EW_GRN) ? ew_car : ns_car;
    opp        = ((state_q == S_EW_GRN) ? ns_car : ew_car) | ped_pend_q;
    green_done = opp && ((timer_q >= T_MIN && !own) || timer_q >= T_MAX);
    state_d    = state_q;
    case (state_q)
      S_EW_GRN: state_d = green_done ? S_EW_YEL : S_EW_GRN;
      S_EW_YEL: state_d = (timer_q == T_YEL) ? S_RED_A : S_EW_YEL;
      S_RED_A:  state_d = (timer_q == T_RED) ? (ped_pend_q ? S_WALK : S_NS_GRN) : S_RED_A;
      S_NS_GRN: state_d = green_done ? S_NS_YEL : S_NS_GRN;
      S_NS_YEL: state_d = (timer_q == T_YEL) ? S_RED_B : S_NS_YEL;
      S_RED_B:  state_d = (timer_q == T_RED) ? (ped_pend_q ? S_WALK : S_EW_GRN) : S_RED_B;
      S_WALK:   state_d = (timer_q == T_WLK) ? (dir_ns_q ? S_NS_GRN : S_EW_GRN) : S_WALK;
      default:  state_d = S_EW_GRN;
    endcase
    timer_d    = (state_d != state_q) ? '0 : (green && timer_q == T_MAX) ? timer_q : timer_q + CNT_W'(1);
    // entering WALK clears the request even if the button is pressed on that same edge
    ped_pend_d = (state_d == S_WALK && state_q != S_WALK) ? 1'b0 : ped_pend_q | (ped_req && state_q != S_WALK);
    dir_ns_d   = (state_q == S_EW_YEL) ? 1'b1 : (state_q == S_NS_YEL) ? 1'b0 : dir_ns_q;
  end
  always_comb begin
    ew_lite = (state_q == S_EW_GRN) ? 2'b10 : (state_q == S_EW_YEL) ? 2'b01 : 2'b00;
    ns_lite = (state_q == S_NS_GRN) ? 2'b10 : (state_q == S_NS_YEL) ? 2'b01 : 2'b00;
    walk    = state_q == S_WALK;
    phase   = state_q;
  end
endmodule

// File: doc/traffic_phase_sched.md
Name: traffic_phase_sched

Overview:
- Timed phase scheduler for a two-road intersection; supersedes the untimed one-bit light FSM.
- Shares the intersection between the EW and NS car sensors and a pedestrian button.
- Enforces minimum and maximum green, fixed yellow, all-red clearance and a pedestrian walk interval.
- Drives the light heads and the walk lamp directly; sits between the sensor synchronisers and the lamp drivers.

Parameters:
MIN_GREEN, 8, minimum green duration in clock cycles (>=1)
MAX_GREEN, 32, green duration after which opposing demand forces a change (>=MIN_GREEN)
YELLOW_T, 3, yellow duration in cycles (>=1)
ALLRED_T, 2, all-red clearance duration in cycles (>=1)
WALK_T, 6, pedestrian walk duration in cycles (>=1)
CNT_W, 6, phase timer width; must hold MAX_GREEN-1

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
ew_car  input  1  EW vehicle present (already synchronous)
ns_car  input  1  NS vehicle present
ped_req  input  1  pedestrian button, level or pulse
ew_lite  output  2  EW head: 00 red, 01 yellow, 10 green
ns_lite  output  2  NS head, same encoding
walk  output  1  walk lamp
phase  output  3  current state code, for debug

Behaviour:
- The design has one clock; reset is asynchronous and active-low (reset_n). All state updates occur on the rising edge of clock.
- States and codes: EW_GRN=0, EW_YEL=1, RED_A=2, NS_GRN=3, NS_YEL=4, RED_B=5, WALK=6. Code 7 is illegal and recovers to EW_GRN on the next edge.
- Outputs are a Moore decode of the state only; there is no combinational path from inputs to outputs.
- Light decode: EW_GRN gives ew=10, ns=00. EW_YEL gives ew=01, ns=00. NS_GRN gives ew=00, ns=10. NS_YEL gives ew=00, ns=01. RED_A, RED_B and WALK give 00/00. walk=1 only in WALK.
- Reset (reset_n low, immediate and asynchronous): state=EW_GRN, timer=0, ped_pend=0, so ew_lite=10, ns_lite=00, walk=0, phase=0. Reset asserted mid-phase aborts that phase immediately.
- Timer behaviour:
  - Clears to 0 on every state change.
  - Otherwise increments by 1 per cycle.
  - In green states it saturates at MAX_GREEN-1; it never wraps.
- ped_pend:
  - Set on any cycle with ped_req=1, except while in WALK or on the edge that enters WALK.
  - Cleared on the edge that enters WALK; clear wins over a simultaneous set.
- Green exit rule (EW_GRN shown; NS_GRN is symmetric). Let opp = ns_car | ped_pend. Move to EW_YEL when either:
  - timer >= MIN_GREEN-1 and opp and !ew_car, or
  - timer >= MAX_GREEN-1 and opp.
  With no opposing demand the green holds indefinitely.
- Timed exits:
  - EW_YEL lasts exactly YELLOW_T cycles, then goes to RED_A.
  - NS_YEL lasts exactly YELLOW_T cycles, then goes to RED_B.
  - RED_A and RED_B last exactly ALLRED_T cycles.
- Clearance exits: on leaving RED_A, go to WALK if ped_pend=1, else NS_GRN. On leaving RED_B, go to WALK if ped_pend=1, else EW_GRN.
- WALK lasts exactly WALK_T cycles, then goes to the green opposite the last yellow. A 1-bit next_dir register records this (set in EW_YEL to NS, in NS_YEL to EW; reset value NS).
- Green is therefore at least MIN_GREEN cycles. Exact green durations: MIN_GREEN when demand is already waiting and the own road is empty; MAX_GREEN under continuous demand on both roads.
- Safety invariant: ew_lite and ns_lite are never both non-red.

Test Plan:
- Reset with defaults; hold ew_car=0, ns_car=0, ped_req=0 for 100 cycles -> ew_lite=10 throughout, phase=0, walk=0.
- ns_car=1 from reset, ew_car=0 -> EW green for 8 cycles, yellow 3, all-red 2, then ns_lite=10 at cycle 13.
- ew_car=1 and ns_car=1 held continuously -> EW green 32, yellow 3, red 2, NS green 32, and so on; period 74 cycles.
- 1-cycle ped_req pulse at cycle 2, no cars -> EW green 8, yellow 3, red 2, walk=1 for 6 cycles, then ns_lite=10 with ped_pend=0.
- ped_req held high through WALK and beyond -> no pend during WALK; re-latched on the first cycle after WALK, so a second WALK follows the next green.
- Assert reset_n low for 1 cycle mid NS_YEL -> outputs return to 10/00, phase=0, ped_pend=0 asynchronously. Assertion checks "never both non-red" and "phase!=7" every cycle.
